// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state type and STATUS packing for the MMIO UART transmitter
package uart_pkg;

  // Address decode: the IO page is selected by a single address bit
  localparam int IO_PAGE_BIT = 22;

  // Word offsets within the IO page (mem_addr[4:2])
  localparam logic [2:0] UART_TX_DATA = 3'd0;
  localparam logic [2:0] UART_STATUS  = 3'd1;

  // STATUS register bit positions
  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;

  // Serializer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Pack the STATUS word; unused upper bits read as zero
  function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                              input logic empty, input logic busy);
    logic [31:0] w;
    w            = '0;
    w[STAT_OVF]  = ovf;
    w[STAT_FULL] = full;
    w[STAT_EMPTY]= empty;
    w[STAT_BUSY] = busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - core data-bus signals seen by the IO-page UART transmitter
interface uart_tx_mmio_if;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] io_rdata;

  // Core side drives address, store data, mask and read strobe
  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_wmask,
    output mem_rstrb,
    input  io_rdata
  );

  // Peripheral side decodes the request and returns registered read data
  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_wmask,
    input  mem_rstrb,
    output io_rdata
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head read and push-while-full-with-pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign do_pop   = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and pollable STATUS
module uart_tx_mmio #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           tx_busy
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int FAW          = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  // Bus decode
  logic        io_sel;
  logic [2:0]  offset;
  logic        wr_tx;
  logic        rd_en;
  logic        rd_status;

  // FIFO interface
  logic [7:0]  fifo_rdata;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [FAW:0] fifo_count;

  // Sticky overflow flag
  logic        overflow;
  logic        ovf_event;

  // Serializer state and datapath
  tx_state_e     state, state_n;
  logic [CW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n;
  logic          baud_wrap;

  // Address bits outside the decoded fields, upper store lanes and the FIFO level are not needed here
  logic unused_bits;
  assign unused_bits = ^{bus.mem_addr[31:23], bus.mem_addr[21:5], bus.mem_addr[1:0],
                         bus.mem_wdata[31:8], bus.mem_wmask[3:1], fifo_count};

  assign io_sel    = bus.mem_addr[IO_PAGE_BIT];
  assign offset    = bus.mem_addr[4:2];
  assign wr_tx     = io_sel && bus.mem_wmask[0] && (offset == UART_TX_DATA);
  assign rd_en     = io_sel && bus.mem_rstrb;
  assign rd_status = rd_en && (offset == UART_STATUS);

  assign tx_busy   = (state != ST_IDLE) || !fifo_empty;
  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // A push is lost only when the FIFO is full and the serializer is not popping on the same edge
  assign ovf_event = wr_tx && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_tx),
    .push_data (bus.mem_wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Overflow: set on a dropped push, cleared by a STATUS read; a new drop wins over the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_event) begin
      overflow <= 1'b1;
    end else if (rd_status) begin
      overflow <= 1'b0;
    end
  end

  // Read data register: captured on an IO-page read strobe, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.io_rdata <= '0;
    end else if (rd_en) begin
      if (offset == UART_STATUS) begin
        bus.io_rdata <= status_word(overflow, fifo_full, fifo_empty, tx_busy);
      end else begin
        bus.io_rdata <= '0;
      end
    end
  end

  // Serializer state register and datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
    end
  end

  // Serializer next-state, FIFO pop and next tx level
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_idx;
    shreg_n  = shreg;
    tx_n     = tx;
    fifo_pop = 1'b0;

    if (state != ST_IDLE) begin
      baud_n = baud_wrap ? '0 : baud_cnt + BAUD_ONE;
    end

    case (state)
      ST_IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_n  = fifo_rdata;
          state_n  = ST_START;
          tx_n     = 1'b0;
        end
      end

      ST_START: begin
        if (baud_wrap) begin
          state_n = ST_DATA;
          bit_n   = '0;
          tx_n    = shreg[0];
        end
      end

      ST_DATA: begin
        if (baud_wrap) begin
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
            tx_n    = 1'b1;
          end else begin
            shreg_n = {1'b0, shreg[7:1]};
            bit_n   = bit_idx + 3'd1;
            tx_n    = shreg[1];
          end
        end
      end

      ST_STOP: begin
        if (baud_wrap) begin
          // Chain straight into the next start bit so frames are exactly back to back
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_n  = fifo_rdata;
            state_n  = ST_START;
            tx_n     = 1'b0;
          end else begin
            state_n  = ST_IDLE;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio with a line-level frame decoder
module tb_uart_tx_mmio;

  localparam int CPB   = 10;          // 1000 Hz / 100 baud
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 8;
  localparam logic [31:0] A_TXDATA = 32'h0040_0000;
  localparam logic [31:0] A_STATUS = 32'h0040_0004;
  localparam logic [31:0] A_OFF2   = 32'h0040_0008;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic tx_busy;

  uart_tx_mmio_if bus();

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_data[$];
  int         got_start[$];
  logic       got_stop[$];

  uart_tx_mmio #(
    .CLK_FREQ_HZ (1000),
    .BAUD_RATE   (100),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit ovf, input bit full, input bit empty, input bit busy);
    return {28'd0, ovf, full, empty, busy};
  endfunction

  task automatic bus_write(input logic [31:0] addr, input logic [7:0] b, input logic [3:0] mask,
                           output int edge_cyc);
    bus.mem_addr  = addr;
    bus.mem_wdata = {4{b}};
    bus.mem_wmask = mask;
    @(negedge clk);
    edge_cyc      = cyc;
    bus.mem_wmask = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.mem_addr  = addr;
    bus.mem_rstrb = 1'b1;
    @(negedge clk);
    bus.mem_rstrb = 1'b0;
    data          = bus.io_rdata;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int t = 0; t < budget && got_data.size() < n; t++) @(negedge clk);
  endtask

  task automatic clear_got();
    got_data.delete();
    got_start.delete();
    got_stop.delete();
  endtask

  // Line decoder: start bit on a falling tx, data sampled mid-bit, stop sampled mid-period
  initial begin : monitor
    int         st;
    logic [7:0] d;
    logic       stp;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        st = cyc; d = '0; stp = 1'b0; aborted = 1'b0;
        for (int k = 1; k < FRAME && !aborted; k++) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
          else if (k >= 15 && k <= 85 && (k % 10) == 5) d[(k - 15) / 10] = tx;
          else if (k == 95) stp = tx;
        end
        if (!aborted) begin
          got_data.push_back(d);
          got_start.push_back(st);
          got_stop.push_back(stp);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int          pc, pc0, dummy, n, acc, q;
    logic [31:0] rd;
    logic [7:0]  b;
    logic [7:0]  bytes[$];

    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    bus.mem_rstrb = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rdata", bus.io_rdata, 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    bus_read(A_STATUS, rd);
    check("rst_status", rd, exp_status(0, 0, 1, 0));

    // Single byte 0x41: start one cycle after push, 100-cycle frame, busy drops after
    clear_got();
    bus_write(A_TXDATA, 8'h41, 4'b0001, pc);
    while (cyc < pc + FRAME) @(negedge clk);
    check("t2_busy_stop", 32'(tx_busy), 32'd1);
    check("t2_tx_stop", 32'(tx), 32'd1);
    @(negedge clk);
    check("t2_busy_end", 32'(tx_busy), 32'd0);
    check("t2_count", got_data.size(), 32'd1);
    if (got_data.size() >= 1) begin
      check("t2_start", got_start[0], pc + 1);
      check("t2_data", 32'(got_data[0]), 32'h41);
      check("t2_stopbit", 32'(got_stop[0]), 32'd1);
    end

    // Random single byte
    clear_got();
    b = 8'($urandom);
    bus_write(A_TXDATA, b, 4'b0001, pc);
    wait_frames(1, FRAME + 20);
    check("t2r_count", got_data.size(), 32'd1);
    if (got_data.size() >= 1) check("t2r_data", 32'(got_data[0]), 32'(b));

    // Back-to-back frames
    repeat (5) @(negedge clk);
    clear_got();
    bus_write(A_TXDATA, 8'h55, 4'b0001, pc);
    bus_write(A_TXDATA, 8'hAA, 4'b0001, dummy);
    wait_frames(2, 2 * FRAME + 20);
    check("t3_count", got_data.size(), 32'd2);
    if (got_data.size() >= 2) begin
      check("t3_data0", 32'(got_data[0]), 32'h55);
      check("t3_data1", 32'(got_data[1]), 32'hAA);
      check("t3_gap", got_start[1] - got_start[0], FRAME);
      check("t3_start", got_start[0], pc + 1);
    end

    // Burst writes: first byte leaves the FIFO at once, DEPTH more fit, the rest drop
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 3000 && tx_busy; t++) @(negedge clk);
      check("t4_idle", 32'(tx_busy), 32'd0);
      clear_got();
      bytes.delete();
      n = (r == 0) ? 10 : int'($urandom_range(2, 12));
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        bytes.push_back(b);
        bus_write(A_TXDATA, b, 4'b0001, dummy);
      end
      acc = (n < DEPTH + 1) ? n : DEPTH + 1;
      q   = acc - 1;
      bus_read(A_STATUS, rd);
      check("t4_status", rd, exp_status(n > acc, q == DEPTH, q == 0, 1));
      bus_read(A_STATUS, rd);
      check("t4_status2", rd, exp_status(0, q == DEPTH, q == 0, 1));
      wait_frames(acc, acc * FRAME + 50);
      repeat (FRAME + 20) @(negedge clk);
      check("t4_count", got_data.size(), acc);
      for (int i = 0; i < acc && i < got_data.size(); i++) begin
        check("t4_data", 32'(got_data[i]), 32'(bytes[i]));
        if (i > 0) check("t4_gap", got_start[i] - got_start[i-1], FRAME);
      end
      check("t4_busy_end", 32'(tx_busy), 32'd0);
    end

    // Decode: other page, unmapped offset and wrong byte lane are ignored
    clear_got();
    bus_write(32'h0000_0040, 8'h3C, 4'b0001, dummy);
    bus_write(A_OFF2, 8'h3C, 4'b0001, dummy);
    bus_write(A_TXDATA, 8'h3C, 4'b0010, dummy);
    bus_read(A_TXDATA, rd);
    check("t5_txdata_rd", rd, 32'd0);
    bus_read(A_STATUS, rd);
    check("t5_status", rd, exp_status(0, 0, 1, 0));
    bus_read(32'h0000_0004, rd);
    check("t5_hold", rd, exp_status(0, 0, 1, 0));
    bus_read(A_OFF2, rd);
    check("t5_off2_rd", rd, 32'd0);
    repeat (FRAME) @(negedge clk);
    check("t5_frames", got_data.size(), 32'd0);
    check("t5_busy", 32'(tx_busy), 32'd0);

    // Reset during data bit 3 with two bytes queued
    clear_got();
    bus_write(A_TXDATA, 8'($urandom), 4'b0001, pc0);
    bus_write(A_TXDATA, 8'($urandom), 4'b0001, dummy);
    bus_write(A_TXDATA, 8'($urandom), 4'b0001, dummy);
    while (cyc < pc0 + 1 + 45) @(negedge clk);
    check("t6_tx_low_bit3_window", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_tx_after_rst", 32'(tx), 32'd1);
    check("t6_busy_after_rst", 32'(tx_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_STATUS, rd);
    check("t6_status", rd, exp_status(0, 0, 1, 0));
    repeat (3 * FRAME) @(negedge clk);
    check("t6_frames", got_data.size(), 32'd0);
    check("t6_tx_idle", 32'(tx), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
